// File: rtl/blink_pkg.sv
// Shared types and helpers for the programmable blink sequencer.
// Field widths here set the default CNT_W/REP_W of the top level.
package blink_pkg;

    localparam int BLINK_CNT_W = 8;
    localparam int BLINK_REP_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2
    } blink_state_t;

    typedef struct packed {
        logic [BLINK_CNT_W-1:0] on_len;
        logic [BLINK_CNT_W-1:0] off_len;
        logic [BLINK_REP_W-1:0] reps;
    } blink_cfg_t;

    localparam int BLINK_CFG_W = $bits(blink_cfg_t);

    // True when the tick counter sits on the final tick of a phase of length len (len >= 1).
    function automatic logic last_tick(input logic [BLINK_CNT_W-1:0] cnt,
                                       input logic [BLINK_CNT_W-1:0] len);
        return cnt == (len - BLINK_CNT_W'(1));
    endfunction

    function automatic logic last_rep(input logic [BLINK_REP_W-1:0] cnt,
                                      input logic [BLINK_REP_W-1:0] reps);
        return cnt == (reps - BLINK_REP_W'(1));
    endfunction

endpackage

// File: rtl/blink_channel.sv
// One blink channel: IDLE/ON/OFF state machine with tick and repetition counters
// and its own copy of the configuration captured at start.
module blink_channel
    import blink_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   tick,
    input  logic                   start,
    input  logic                   stop,
    input  logic [BLINK_CFG_W-1:0] cfg_bus,
    output logic                   out,
    output logic                   busy,
    output logic                   done
);

    blink_state_t           state;
    blink_cfg_t             cfg;
    blink_cfg_t             cfg_new;
    logic [BLINK_CNT_W-1:0] tick_cnt;
    logic [BLINK_REP_W-1:0] rep_cnt;

    assign cfg_new = blink_cfg_t'(cfg_bus);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cfg      <= '0;
            tick_cnt <= '0;
            rep_cnt  <= '0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !stop) begin
                        cfg      <= cfg_new;
                        tick_cnt <= '0;
                        rep_cnt  <= '0;
                        // A burst with nothing to show completes immediately.
                        if (cfg_new.reps == '0 || cfg_new.on_len == '0)
                            done <= 1'b1;
                        else
                            state <= ON;
                    end
                end
                ON: begin
                    if (stop) begin
                        state    <= IDLE;
                        tick_cnt <= '0;
                        rep_cnt  <= '0;
                    end else if (tick) begin
                        if (last_tick(tick_cnt, cfg.on_len)) begin
                            tick_cnt <= '0;
                            if (cfg.off_len != '0) begin
                                state <= OFF;
                            end else if (last_rep(rep_cnt, cfg.reps)) begin
                                state   <= IDLE;
                                rep_cnt <= '0;
                                done    <= 1'b1;
                            end else begin
                                rep_cnt <= rep_cnt + BLINK_REP_W'(1);
                            end
                        end else begin
                            tick_cnt <= tick_cnt + BLINK_CNT_W'(1);
                        end
                    end
                end
                OFF: begin
                    if (stop) begin
                        state    <= IDLE;
                        tick_cnt <= '0;
                        rep_cnt  <= '0;
                    end else if (tick) begin
                        if (last_tick(tick_cnt, cfg.off_len)) begin
                            tick_cnt <= '0;
                            if (last_rep(rep_cnt, cfg.reps)) begin
                                state   <= IDLE;
                                rep_cnt <= '0;
                                done    <= 1'b1;
                            end else begin
                                state   <= ON;
                                rep_cnt <= rep_cnt + BLINK_REP_W'(1);
                            end
                        end else begin
                            tick_cnt <= tick_cnt + BLINK_CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    tick_cnt <= '0;
                    rep_cnt  <= '0;
                end
            endcase
        end
    end

    assign out  = (state == ON);
    assign busy = (state == ON) || (state == OFF);

endmodule

// File: rtl/blink_pattern_gen.sv
// N_CH-channel programmable blink sequencer; every channel shares the tick
// strobe and the configuration bus but runs its own independent sequence.
module blink_pattern_gen
    import blink_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int CNT_W = BLINK_CNT_W,
    parameter int REP_W = BLINK_REP_W
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_tick,
    input  logic [N_CH-1:0] i_start,
    input  logic [N_CH-1:0] i_stop,
    input  logic [CNT_W-1:0] i_on_len,
    input  logic [CNT_W-1:0] i_off_len,
    input  logic [REP_W-1:0] i_reps,
    output logic [N_CH-1:0] o_out,
    output logic [N_CH-1:0] o_busy,
    output logic [N_CH-1:0] o_done
);

    // Field order matches blink_cfg_t; CNT_W/REP_W must match the package widths.
    logic [BLINK_CFG_W-1:0] cfg_bus;
    assign cfg_bus = {i_on_len, i_off_len, i_reps};

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        blink_channel u_ch (
            .clk     (i_clk),
            .rst     (i_rst),
            .tick    (i_tick),
            .start   (i_start[g]),
            .stop    (i_stop[g]),
            .cfg_bus (cfg_bus),
            .out     (o_out[g]),
            .busy    (o_busy[g]),
            .done    (o_done[g])
        );
    end

endmodule
